// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM type, round constants and GF(2^8) helpers
// for the iterative AES-128 decryption core.
package aes_pkg;

  localparam int NUM_RK = 11;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    FINAL,
    DONE
  } aes_state_e;

  // Rcon[i] for i = 1..10; unused slots read as zero.
  localparam logic [15:0][7:0] RCON = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
    8'h00
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (0 maps to 0).
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] i;
    i = gf_inv(x);
    return i
      ^ {i[6:0], i[7]}
      ^ {i[5:0], i[7:6]}
      ^ {i[4:0], i[7:5]}
      ^ {i[3:0], i[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] y
  );
    logic [7:0] t;
    t = {y[6:0], y[7]}
      ^ {y[4:0], y[7:5]}
      ^ {y[1:0], y[7:2]}
      ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// aes_inv_round_comb: one combinational inverse round
// (InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns).
module aes_inv_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         bypass_mix,
  output logic [127:0] res
);

  logic [7:0] a [16];
  logic [7:0] k [16];
  logic [7:0] x [16];
  logic [7:0] m [16];

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign a[i] = st[127-8*i -: 8];
    assign k[i] = rk[127-8*i -: 8];
    assign res[127-8*i -: 8] = bypass_mix ? x[i] : m[i];
  end

  // Row rr rotates right by rr columns before the inverse S-box.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar rr = 0; rr < 4; rr++) begin : g_row
      assign x[4*c+rr] =
        inv_sbox(a[4*((c-rr+4)%4)+rr]) ^ k[4*c+rr];
    end

    assign m[4*c+0] = gf_mul(x[4*c+0], 8'h0e)
                    ^ gf_mul(x[4*c+1], 8'h0b)
                    ^ gf_mul(x[4*c+2], 8'h0d)
                    ^ gf_mul(x[4*c+3], 8'h09);
    assign m[4*c+1] = gf_mul(x[4*c+0], 8'h09)
                    ^ gf_mul(x[4*c+1], 8'h0e)
                    ^ gf_mul(x[4*c+2], 8'h0b)
                    ^ gf_mul(x[4*c+3], 8'h0d);
    assign m[4*c+2] = gf_mul(x[4*c+0], 8'h0d)
                    ^ gf_mul(x[4*c+1], 8'h09)
                    ^ gf_mul(x[4*c+2], 8'h0e)
                    ^ gf_mul(x[4*c+3], 8'h0b);
    assign m[4*c+3] = gf_mul(x[4*c+0], 8'h0b)
                    ^ gf_mul(x[4*c+1], 8'h0d)
                    ^ gf_mul(x[4*c+2], 8'h09)
                    ^ gf_mul(x[4*c+3], 8'h0e);
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 decryptor, one round per
// cycle, with a round-key cache that survives between jobs.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in,
  input  logic [N-1:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out,
  output logic           busy
);

  localparam logic [3:0] LAST_RK = 4'(Nr);
  localparam logic [3:0] FIRST_R = 4'(Nr - 1);

  aes_state_e   fsm;
  logic [127:0] st;
  logic [127:0] rk [NUM_RK];
  logic         key_cached;
  logic [3:0]   r;
  logic [3:0]   kidx;

  logic [127:0] rk_prev;
  logic [127:0] rk_next;
  logic [31:0]  kw [Nk];
  logic [31:0]  nw [Nk];
  logic [31:0]  ktmp;

  logic [127:0] rk_sel;
  logic [127:0] rnd;
  logic         is_final;

  assign rk_prev = rk[kidx - 4'd1];

  for (genvar j = 0; j < Nk; j++) begin : g_kw
    assign kw[j] = rk_prev[127-32*j -: 32];
    assign rk_next[127-32*j -: 32] = nw[j];
  end

  assign ktmp = sub_word({kw[Nk-1][23:0], kw[Nk-1][31:24]})
              ^ {RCON[kidx], 24'h0};
  assign nw[0] = kw[0] ^ ktmp;

  for (genvar j = 1; j < Nk; j++) begin : g_nw
    assign nw[j] = kw[j] ^ nw[j-1];
  end

  assign is_final = (fsm == FINAL);
  assign rk_sel   = is_final ? rk[0] : rk[r];

  aes_inv_round_comb u_round (
    .st         (st),
    .rk         (rk_sel),
    .bypass_mix (is_final),
    .res        (rnd)
  );

  // Control FSM, datapath registers and registered handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out        <= '0;
      key_cached <= 1'b0;
      r          <= '0;
      kidx       <= '0;
      st         <= '0;
      for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            st       <= in;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (key_cached && key == rk[0]) begin
              fsm <= INIT;
            end else begin
              rk[0]      <= key;
              key_cached <= 1'b0;
              kidx       <= 4'd1;
              fsm        <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          rk[kidx] <= rk_next;
          kidx     <= kidx + 4'd1;
          if (kidx == LAST_RK) begin
            key_cached <= 1'b1;
            fsm        <= INIT;
          end
        end
        INIT: begin
          st  <= st ^ rk[NUM_RK-1];
          r   <= FIRST_R;
          fsm <= ROUND;
        end
        ROUND: begin
          st <= rnd;
          r  <= r - 4'd1;
          if (r == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          st        <= rnd;
          out       <= rnd;
          out_valid <= 1'b1;
          fsm       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
